debug_responder: RTL and testbench

CPU-side responder for the debug interface. It answers the debugger's strobed register accesses (`stb`/`we`/`adr`/`datI`) with `ack`/`datO`, and it owns the run/halt/single-step state machine that drives the core stall request. It sits between the debug peripheral and the processor core, next to the power manager on the core's stall input.

---
 rtl/debug_responder.sv | 171 +++++++++++++++++
 tb/tb_debug_responder.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_responder.sv
// Debug register responder with run/halt/single-step control.
// Answers strobed debugger accesses and drives the core stall request.
module debug_responder #(
    parameter int unsigned ACK_LATENCY = 1,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stb,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] datI,
    output logic [31:0] datO,
    output logic        ack,
    input  logic        stall,
    input  logic        ewt,
    input  logic [31:0] cpuPc,
    input  logic        cpuRetire,
    output logic        cpuStallReq,
    output logic        bp
);

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] HALTED = 2'd1;
    localparam logic [1:0] STEP   = 2'd2;

    localparam logic [3:0] LAT = 4'(ACK_LATENCY);

    logic [1:0]  state;
    logic [3:0]  waitCnt;
    logic        haltReq;
    logic        bpEnable;
    logic        bpHit;
    logic        stepDone;
    logic [31:0] bpAddr;
    logic [31:0] pcCap;
    logic [31:0] retCnt;
    logic [31:0] scratch;

    logic        commit;
    logic        mapped;
    logic [2:0]  slot;
    logic        wr;
    logic        wrCtrl;
    logic        wrStatus;
    logic        wrBp;
    logic        wrCnt;
    logic        wrScr;
    logic        stepReq;
    logic        bpMatch;
    logic        hwHalt;
    logic        runHalt;
    logic        stepEnd;
    logic [31:0] rdData;

    // waitCnt counts sampled strobe edges; the edge after LAT of them commits
    assign commit   = stb && (waitCnt == LAT);
    assign mapped   = (adr[31:5] == 27'd0);
    assign slot     = adr[4:2];
    assign wr       = commit && we && mapped;
    assign wrCtrl   = wr && (slot == 3'd0);
    assign wrStatus = wr && (slot == 3'd1);
    assign wrBp     = wr && (slot == 3'd2);
    assign wrCnt    = wr && (slot == 3'd4);
    assign wrScr    = wr && (slot == 3'd5);
    assign stepReq  = wrCtrl && datI[2] && datI[0];

    assign bpMatch  = bpEnable && cpuRetire && (cpuPc == bpAddr);
    assign hwHalt   = (state == RUN) && (ewt || bpMatch);
    assign runHalt  = (state == RUN) && (haltReq || ewt || bpMatch);
    assign stepEnd  = (state == STEP) && cpuRetire;

    assign cpuStallReq = stall || (state == HALTED);

    always_comb begin
        rdData = '0;
        if (mapped) begin
            case (slot)
                3'd0:    rdData = {30'd0, bpEnable, haltReq};
                3'd1:    rdData = {29'd0, stepDone, bpHit, state == HALTED};
                3'd2:    rdData = bpAddr;
                3'd3:    rdData = pcCap;
                3'd4:    rdData = retCnt;
                3'd5:    rdData = scratch;
                default: rdData = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            waitCnt <= '0;
            ack     <= 1'b0;
            datO    <= '0;
        end else begin
            ack  <= commit;
            datO <= commit ? rdData : '0;
            if (!stb || commit) begin
                waitCnt <= '0;
            end else begin
                waitCnt <= waitCnt + 4'd1;
            end
        end
    end

    // hardware sets are written last so they win over software clears
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            haltReq  <= 1'b0;
            bpEnable <= 1'b0;
            bpHit    <= 1'b0;
            stepDone <= 1'b0;
        end else begin
            if (wrCtrl) begin
                haltReq  <= datI[0];
                bpEnable <= datI[1];
            end
            if (wrStatus && datI[1]) bpHit <= 1'b0;
            if (wrStatus && datI[2]) stepDone <= 1'b0;
            if (hwHalt) begin
                haltReq <= 1'b1;
                bpHit   <= 1'b1;
            end
            if (stepEnd) stepDone <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bpAddr  <= '0;
            scratch <= '0;
            retCnt  <= '0;
            pcCap   <= RESET_PC;
        end else begin
            if (wrBp) bpAddr <= datI;
            if (wrScr) scratch <= datI;
            if (wrCnt) begin
                retCnt <= '0;
            end else if (cpuRetire) begin
                retCnt <= retCnt + 32'd1;
            end
            if (runHalt || stepEnd) pcCap <= cpuPc;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
            bp    <= 1'b0;
        end else begin
            bp <= hwHalt;
            case (state)
                RUN: begin
                    if (runHalt) state <= HALTED;
                end
                HALTED: begin
                    if (!haltReq) begin
                        state <= RUN;
                    end else if (stepReq) begin
                        state <= STEP;
                    end
                end
                STEP: begin
                    if (cpuRetire) state <= HALTED;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_responder.sv
// Bench for debug_responder: vector table, hand sequences for
// halt/step/contention corners, and a randomized register model.
module tb_debug_responder;

    localparam int          LAT    = 3;
    localparam logic [31:0] PC_RST = 32'h1000_0000;

    logic        clock;
    logic        reset_n;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] datI;
    logic [31:0] datO;
    logic        ack;
    logic        stall;
    logic        ewt;
    logic [31:0] cpuPc;
    logic        cpuRetire;
    logic        cpuStallReq;
    logic        bp;

    debug_responder #(
        .ACK_LATENCY(LAT),
        .RESET_PC   (PC_RST)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .stb        (stb),
        .we         (we),
        .adr        (adr),
        .datI       (datI),
        .datO       (datO),
        .ack        (ack),
        .stall      (stall),
        .ewt        (ewt),
        .cpuPc      (cpuPc),
        .cpuRetire  (cpuRetire),
        .cpuStallReq(cpuStallReq),
        .bp         (bp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          nChk;
    int          nFail;
    int          datOLeak;
    bit          rndRet;
    logic [31:0] mcnt;
    logic [31:0] mbp;
    logic [31:0] mscr;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] e;
        string       nm;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nChk++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference read value from the register map, given the model state.
    function automatic logic [31:0] expRead(input logic [31:0] a,
                                            input logic [31:0] cnt);
        if (a[31:5] != 27'd0) return 32'h0;
        case (a[4:2])
            3'd2:    return mbp;
            3'd3:    return PC_RST;
            3'd4:    return cnt;
            3'd5:    return mscr;
            default: return 32'h0;
        endcase
    endfunction

    task automatic access(input logic w, input logic [31:0] a,
                          input logic [31:0] d, input bit retAck,
                          input logic [31:0] rpc, output logic [31:0] rd,
                          output logic [31:0] pre);
        int n;
        bit got;
        @(negedge clock);
        stb  = 1'b1;
        we   = w;
        adr  = a;
        datI = d;
        got  = 0;
        n    = 0;
        rd   = '0;
        pre  = mcnt;
        while (!got && n < 20) begin
            if (retAck) begin
                cpuRetire = (n == LAT);
                cpuPc     = rpc;
            end else if (rndRet) begin
                cpuRetire = 1'($urandom_range(0, 1));
                cpuPc     = $urandom;
            end else begin
                cpuRetire = 1'b0;
            end
            @(posedge clock);
            pre = mcnt;
            if (cpuRetire) mcnt = mcnt + 32'd1;
            #1;
            if (ack) begin
                got = 1;
                rd  = datO;
                if (w && a[31:5] == 27'd0 && a[4:2] == 3'd4) mcnt = '0;
            end else if (datO != 32'h0) begin
                datOLeak++;
            end
            n++;
            if (!got) @(negedge clock);
        end
        chk("ack latency", 32'(n), 32'(LAT + 1));
        @(negedge clock);
        stb       = 1'b0;
        we        = 1'b0;
        cpuRetire = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        logic [31:0] p;
        access(1'b1, a, d, 1'b0, 32'h0, r, p);
    endtask

    task automatic rdChk(input string nm, input logic [31:0] a,
                         input logic [31:0] e);
        logic [31:0] r;
        logic [31:0] p;
        access(1'b0, a, 32'h0, 1'b0, 32'h0, r, p);
        chk(nm, r, e);
    endtask

    task automatic doReset();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        mcnt = '0;
        mbp  = '0;
        mscr = '0;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] p;
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
        logic [2:0]  s;
        bit          sawAck;

        nChk = 0; nFail = 0; datOLeak = 0; rndRet = 0;
        mcnt = '0; mbp = '0; mscr = '0;
        reset_n = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; datI = '0;
        stall = 1'b0; ewt = 1'b0; cpuPc = '0; cpuRetire = 1'b0;

        tbl[0]  = '{1'b1, 32'h14, 32'hA5A5_1234, 32'h0, "wr scratch"};
        tbl[1]  = '{1'b0, 32'h14, 32'h0, 32'hA5A5_1234, "rd scratch"};
        tbl[2]  = '{1'b0, 32'h00, 32'h0, 32'h0, "rd ctrl reset"};
        tbl[3]  = '{1'b0, 32'h04, 32'h0, 32'h0, "rd status reset"};
        tbl[4]  = '{1'b0, 32'h0C, 32'h0, PC_RST, "rd pc reset"};
        tbl[5]  = '{1'b1, 32'h08, 32'h0000_0100, 32'h0, "wr bpaddr"};
        tbl[6]  = '{1'b0, 32'h08, 32'h0, 32'h0000_0100, "rd bpaddr"};
        tbl[7]  = '{1'b1, 32'h40, 32'h3, 32'h0, "wr high adr"};
        tbl[8]  = '{1'b0, 32'h40, 32'h0, 32'h0, "rd high adr"};
        tbl[9]  = '{1'b0, 32'h00, 32'h0, 32'h0, "ctrl after high wr"};
        tbl[10] = '{1'b0, 32'h14, 32'h0, 32'hA5A5_1234, "scratch kept"};
        tbl[11] = '{1'b1, 32'h00, 32'h4, 32'h0, "step in run"};
        tbl[12] = '{1'b0, 32'h04, 32'h0, 32'h0, "status after step run"};
        tbl[13] = '{1'b0, 32'h18, 32'h0, 32'h0, "rd unmapped"};
        tbl[14] = '{1'b1, 32'h18, 32'hFFFF_FFFF, 32'h0, "wr unmapped"};
        tbl[15] = '{1'b0, 32'h14, 32'h0, 32'hA5A5_1234, "scratch kept 2"};

        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // reset while a read of PC is being acknowledged
        @(negedge clock);
        stb = 1'b1; we = 1'b0; adr = 32'h0C;
        repeat (LAT + 1) @(posedge clock);
        #1;
        chk("pre-reset ack", 32'(ack), 32'h1);
        chk("pre-reset datO", datO, PC_RST);
        stall = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("reset ack", 32'(ack), 32'h0);
        chk("reset datO", datO, 32'h0);
        chk("reset stall hi", 32'(cpuStallReq), 32'h1);
        stall = 1'b0;
        #1;
        chk("reset stall lo", 32'(cpuStallReq), 32'h0);
        chk("reset bp", 32'(bp), 32'h0);
        stb = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            access(tbl[i].w, tbl[i].a, tbl[i].d, 1'b0, 32'h0, r, p);
            if (!tbl[i].w) begin
                chk(tbl[i].nm, r, tbl[i].e);
                @(posedge clock);
                #1;
                chk("datO after ack", datO, 32'h0);
            end
        end

        // abort after one sampled edge
        @(negedge clock);
        stb = 1'b1; we = 1'b1; adr = 32'h14; datI = 32'h0;
        @(negedge clock);
        stb = 1'b0; we = 1'b0;
        sawAck = 0;
        repeat (6) begin
            @(posedge clock);
            #1;
            if (ack) sawAck = 1;
        end
        chk("abort no ack", 32'(sawAck), 32'h0);
        rdChk("abort scratch", 32'h14, 32'hA5A5_1234);
        chk("datO idle", 32'(datOLeak), 32'h0);

        // breakpoint
        wr(32'h00, 32'h2);
        cpuPc = 32'h0FC; cpuRetire = 1'b1;
        @(posedge clock);
        #1;
        chk("no bp at 0FC", 32'(bp), 32'h0);
        chk("no stall at 0FC", 32'(cpuStallReq), 32'h0);
        @(negedge clock);
        cpuPc = 32'h100;
        @(posedge clock);
        #1;
        chk("bp pulse", 32'(bp), 32'h1);
        chk("bp stall", 32'(cpuStallReq), 32'h1);
        @(negedge clock);
        cpuRetire = 1'b0;
        @(posedge clock);
        #1;
        chk("bp one cycle", 32'(bp), 32'h0);
        rdChk("bp status", 32'h04, 32'h3);
        rdChk("bp pc", 32'h0C, 32'h100);
        rdChk("bp ctrl", 32'h00, 32'h3);

        // single step
        wr(32'h00, 32'h5);
        chk("step stall low", 32'(cpuStallReq), 32'h0);
        cpuPc = 32'h104; cpuRetire = 1'b1;
        @(posedge clock);
        #1;
        chk("step back halted", 32'(cpuStallReq), 32'h1);
        @(negedge clock);
        cpuRetire = 1'b0;
        rdChk("step status", 32'h04, 32'h7);
        rdChk("step pc", 32'h0C, 32'h104);
        wr(32'h00, 32'h0);
        @(posedge clock);
        #1;
        chk("resume run", 32'(cpuStallReq), 32'h0);
        rdChk("run status", 32'h04, 32'h6);

        // W1C racing a new breakpoint hit
        wr(32'h04, 32'h6);
        rdChk("w1c clear", 32'h04, 32'h0);
        wr(32'h00, 32'h2);
        access(1'b1, 32'h04, 32'h2, 1'b1, 32'h100, r, p);
        rdChk("bpHit beats w1c", 32'h04, 32'h3);
        wr(32'h00, 32'h0);
        wr(32'h04, 32'h2);
        rdChk("status cleared", 32'h04, 32'h0);

        // RETCNT clear racing a retire
        access(1'b1, 32'h10, 32'h0, 1'b1, 32'h0, r, p);
        rdChk("retcnt clear wins", 32'h10, 32'h0);

        // external watchpoint
        @(negedge clock);
        cpuPc = 32'h2468; ewt = 1'b1;
        @(posedge clock);
        #1;
        chk("ewt bp", 32'(bp), 32'h1);
        chk("ewt stall", 32'(cpuStallReq), 32'h1);
        @(negedge clock);
        ewt = 1'b0;
        rdChk("ewt status", 32'h04, 32'h3);
        rdChk("ewt ctrl", 32'h00, 32'h1);
        rdChk("ewt pc", 32'h0C, 32'h2468);
        wr(32'h00, 32'h0);
        wr(32'h04, 32'h2);

        // RETCNT wrap
        @(negedge clock);
        force dut.retCnt = 32'hFFFF_FFFE;
        #1 release dut.retCnt;
        cpuRetire = 1'b1;
        @(negedge clock);
        cpuRetire = 1'b0;
        rdChk("retcnt max", 32'h10, 32'hFFFF_FFFF);
        @(negedge clock);
        cpuRetire = 1'b1;
        @(negedge clock);
        cpuRetire = 1'b0;
        rdChk("retcnt wrap", 32'h10, 32'h0);

        // randomized accesses against the register model
        doReset();
        rndRet = 1;
        for (int i = 0; i < 60; i++) begin
            s = 3'($urandom_range(0, 7));
            a = {27'd0, s, 2'b00};
            if ($urandom_range(0, 3) == 0) a[31:5] = 27'($urandom) | 27'd1;
            w = 1'($urandom_range(0, 1));
            if (a[31:5] == 27'd0 && (s == 3'd0 || s == 3'd1)) w = 1'b0;
            d = $urandom;
            access(w, a, d, 1'b0, 32'h0, r, p);
            if (!w) begin
                chk("rand read", r, expRead(a, p));
            end else if (a[31:5] == 27'd0) begin
                if (s == 3'd2) mbp = d;
                if (s == 3'd5) mscr = d;
            end
        end
        rndRet = 0;
        rdChk("rand final retcnt", 32'h10, mcnt);
        chk("datO idle final", 32'(datOLeak), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChk, nFail);
        $finish;
    end

endmodule
